// File: rtl/lfsr_seq_checker.sv
// Lock-and-check receiver for the 5-bit game LFSR serial stream (s[4]^s[2]).
// Define LFSR_RESYNC_EN to make LOST a one-cycle pulse followed by reacquisition.
module lfsr_seq_checker #(
    parameter int unsigned ERR_LIMIT = 3,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             preset,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic             stuck,
    output logic             lost
);

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        CHECK   = 2'd1,
        LOST    = 2'd2
    } state_e;

    localparam logic [3:0]       LIMIT   = 4'(ERR_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [4:0]       r_q, r_d;
    logic [2:0]       fill_q, fill_d;
    logic [3:0]       consec_q, consec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             stuck_q, stuck_d;
    logic             locked_q, locked_d;
    logic             lost_q, lost_d;

    logic       pred;
    logic       miss;
    logic [4:0] shift_din;
    logic [2:0] fill_inc;
    logic [3:0] consec_inc;

    assign pred       = r_q[4] ^ r_q[2];
    assign miss       = din ^ pred;
    assign shift_din  = {r_q[3:0], din};
    assign fill_inc   = (fill_q == 3'd5) ? 3'd5 : fill_q + 3'd1;
    assign consec_inc = consec_q + 4'd1;

    always_ff @(posedge clk or negedge preset) begin
        if (!preset) begin
            state_q <= ACQUIRE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ACQUIRE;
        end else begin
            unique case (state_q)
                ACQUIRE: begin
                    if (en && fill_inc == 3'd5 && shift_din != 5'd0)
                        state_d = CHECK;
                end
                CHECK: begin
                    if (en && miss && consec_inc == LIMIT)
                        state_d = LOST;
                end
                LOST: begin
`ifdef LFSR_RESYNC_EN
                    state_d = ACQUIRE;
`else
                    state_d = LOST;
`endif
                end
                default: state_d = ACQUIRE;
            endcase
        end
    end

    always_comb begin
        r_d      = r_q;
        fill_d   = fill_q;
        consec_d = consec_q;
        cnt_d    = cnt_q;
        pulse_d  = 1'b0;
        stuck_d  = stuck_q;
        if (clr) begin
            r_d      = 5'd0;
            fill_d   = 3'd0;
            consec_d = 4'd0;
            cnt_d    = '0;
            stuck_d  = 1'b0;
        end else begin
            unique case (state_q)
                ACQUIRE: begin
                    if (en) begin
                        r_d      = shift_din;
                        fill_d   = fill_inc;
                        consec_d = 4'd0;
                        if (fill_inc == 3'd5)
                            stuck_d = (shift_din == 5'd0);
                    end
                end
                CHECK: begin
                    // Flywheel: keep the predicted bit so one bad bit is one error.
                    if (en && miss) begin
                        r_d      = {r_q[3:0], pred};
                        pulse_d  = 1'b1;
                        consec_d = consec_inc;
                        if (cnt_q != CNT_MAX)
                            cnt_d = cnt_q + CNT_ONE;
                    end else if (en) begin
                        r_d      = shift_din;
                        consec_d = 4'd0;
                    end
                end
                LOST: begin
`ifdef LFSR_RESYNC_EN
                    r_d      = 5'd0;
                    fill_d   = 3'd0;
                    consec_d = 4'd0;
`endif
                end
                default: begin
                    r_d = 5'd0;
                end
            endcase
        end
        locked_d = (state_d == CHECK);
        lost_d   = (state_d == LOST);
    end

    always_ff @(posedge clk or negedge preset) begin
        if (!preset) begin
            r_q      <= 5'd0;
            fill_q   <= 3'd0;
            consec_q <= 4'd0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
            stuck_q  <= 1'b0;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            r_q      <= r_d;
            fill_q   <= fill_d;
            consec_q <= consec_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
            stuck_q  <= stuck_d;
            locked_q <= locked_d;
            lost_q   <= lost_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = pulse_q;
    assign err_cnt   = cnt_q;
    assign stuck     = stuck_q;
    assign lost      = lost_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Randomised bench for lfsr_seq_checker against a queue-based stream model.
// A second instance with CNT_W=2 covers counter saturation.
module tb_lfsr_seq_checker;

    localparam int LIM = 3;

    logic clk;
    logic preset;
    logic clr;
    logic en;
    logic din;

    logic       locked, err_pulse, stuck, lost;
    logic [7:0] err_cnt;
    logic       locked2, err_pulse2, stuck2, lost2;
    logic [1:0] err_cnt2;

    lfsr_seq_checker #(.ERR_LIMIT(LIM), .CNT_W(8)) u_dut (
        .clk(clk), .preset(preset), .clr(clr), .en(en), .din(din),
        .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt),
        .stuck(stuck), .lost(lost)
    );

    lfsr_seq_checker #(.ERR_LIMIT(LIM), .CNT_W(2)) u_dut2 (
        .clk(clk), .preset(preset), .clr(clr), .en(en), .din(din),
        .locked(locked2), .err_pulse(err_pulse2), .err_cnt(err_cnt2),
        .stuck(stuck2), .lost(lost2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model: mode 0=acquire 1=check 2=lost; win holds the last five bits.
    int mode;
    bit win[$];
    int run;
    int ecnt;
    bit m_pulse;
    bit m_stuck;

    function automatic void model_reset(input bit keep_cnt);
        mode = 0;
        win.delete();
        run = 0;
        if (!keep_cnt) ecnt = 0;
        m_pulse = 0;
        m_stuck = 0;
    endfunction

    function automatic int ones();
        int n = 0;
        foreach (win[i]) n += int'(win[i]);
        return n;
    endfunction

    function automatic bit m_pred();
        return win[0] ^ win[2];
    endfunction

    function automatic void model_step(input bit c, input bit e, input bit d);
        bit p;
        m_pulse = 0;
        if (c) begin
            model_reset(0);
        end else if (mode == 2) begin
`ifdef LFSR_RESYNC_EN
            model_reset(1);
`endif
        end else if (e && mode == 0) begin
            win.push_back(d);
            if (win.size() > 5) void'(win.pop_front());
            if (win.size() == 5) begin
                if (ones() == 0) begin
                    m_stuck = 1;
                end else begin
                    m_stuck = 0;
                    mode = 1;
                    run = 0;
                end
            end
        end else if (e && mode == 1) begin
            p = m_pred();
            if (d != p) begin
                ecnt++;
                m_pulse = 1;
                run++;
                win.push_back(p);
                if (run == LIM) mode = 2;
            end else begin
                run = 0;
                win.push_back(d);
            end
            void'(win.pop_front());
        end
    endfunction

    task automatic compare_all(input string tag);
        chk({tag, ".locked"}, 32'(locked), 32'(mode == 1));
        chk({tag, ".lost"}, 32'(lost), 32'(mode == 2));
        chk({tag, ".stuck"}, 32'(stuck), 32'(m_stuck));
        chk({tag, ".pulse"}, 32'(err_pulse), 32'(m_pulse));
        chk({tag, ".cnt"}, 32'(err_cnt), (ecnt > 255) ? 255 : ecnt);
        chk({tag, ".pulse2"}, 32'(err_pulse2), 32'(m_pulse));
        chk({tag, ".cnt2"}, 32'(err_cnt2), (ecnt > 3) ? 3 : ecnt);
    endtask

    bit [4:0] g;

    function automatic bit gen_bit();
        bit b = g[4];
        g = {g[3:0], g[4] ^ g[2]};
        return b;
    endfunction

    task automatic cycle(input string tag, input bit c, input bit e,
                         input bit d);
        clr = c;
        en  = e;
        din = d;
        @(posedge clk);
        model_step(c, e, d);
        #1;
        compare_all(tag);
    endtask

    task automatic do_preset(input string tag);
        #2;
        preset = 1'b0;
        en     = 1'b0;
        clr    = 1'b0;
        model_reset(0);
        #1;
        compare_all(tag);
        @(posedge clk);
        #1;
        preset = 1'b1;
    endtask

    initial begin
        int pos;
        int acc;
        bit e;
        bit b;
        preset = 1'b0;
        clr    = 1'b0;
        en     = 1'b0;
        din    = 1'b0;
        model_reset(0);
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        preset = 1'b1;

        g = 5'b00001;
        for (int i = 0; i < 11; i++) cycle("seed", 0, 1, gen_bit());
        chk("seed_lock", 32'(locked), 1);

        pos = $urandom_range(3, 27);
        for (int i = 0; i < 31; i++) begin
            b = gen_bit();
            if (i == pos) b = ~b;
            cycle("one_err", 0, 1, b);
        end
        chk("one_err_cnt", 32'(err_cnt), 1);

        for (int i = 0; i < LIM; i++) cycle("inv", 0, 1, ~m_pred());
        chk("inv_lost", 32'(lost), 1);
        for (int i = 0; i < 20; i++)
            cycle("lost_hold", 0, 1'($urandom), 1'($urandom));
        cycle("clr", 1, 1'($urandom), 1'($urandom));

        do_preset("preset0");
        for (int i = 0; i < 8; i++) cycle("zeros", 0, 1, 0);
        chk("stuck_set", 32'(stuck), 1);
        cycle("wake", 0, 1, 1);
        for (int i = 0; i < 4; i++) cycle("wake", 0, 1, 0);
        chk("wake_lock", 32'(locked), 1);

        cycle("clr2", 1, 0, 0);
        for (int i = 0; i < 5; i++) cycle("sat_lock", 0, 1, gen_bit());
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 6; i++) cycle("sat_ok", 0, 1, gen_bit());
            cycle("sat_err", 0, 1, ~gen_bit());
        end
        chk("sat_cnt2", 32'(err_cnt2), 3);
        chk("sat_cnt8", 32'(err_cnt), 5);
        cycle("sat_clr", 1, 1, 1);
        chk("sat_clr_cnt", 32'(err_cnt2), 0);

        cycle("clr3", 1, 0, 0);
        for (int i = 0; i < 100 && mode != 1; i++) begin
            e = 1'($urandom);
            cycle("gap", 0, e, e ? gen_bit() : 1'($urandom));
        end
        chk("gap_lock", 32'(locked), 1);
        for (int i = 0; i < 10; i++) begin
            e = 1'($urandom);
            cycle("gap_run", 0, e, e ? gen_bit() : 1'($urandom));
        end
        do_preset("preset_mid");
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            e = 1'($urandom);
            if (e) acc++;
            cycle("relock", 0, e, e ? gen_bit() : 1'($urandom));
            if (acc < 5) chk("relock_early", 32'(locked), 0);
        end

        for (int i = 0; i < 3000; i++) begin
            e = ($urandom % 4) != 0;
            b = e ? gen_bit() : 1'($urandom);
            if (($urandom % 40) == 0) b = ~b;
            cycle("rand", ($urandom % 200) == 0, e, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
